conv_line_buffer: RTL and testbench
===================================

Name: conv_line_buffer

Overview:
- Parametrised multi-line buffer for the Conv path, successor to the single 512x8 simple-dual-port RAM wrapper.
- Accepts a raster pixel stream and emits, per accepted pixel, a vertical column of NUM_LINES+1 taps (current row plus NUM_LINES previous rows) with a valid/ready handshake and selectable output register.
- Sits between pixel source and the KxK convolution window generator.
- One clock domain; line memories are NUM_LINES instances of a single-clock SDP RAM.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- LINE_WIDTH, 512, maximum pixels per line (RAM depth).
- ADDR_WIDTH, 9, column address width; must satisfy 2^ADDR_WIDTH >= LINE_WIDTH.
- NUM_LINES, 2, stored previous lines (taps = NUM_LINES+1); range 1..8.
- OUTPUT_REG, 0, 1 adds an output register stage (latency 2 instead of 1).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_line_len  in  ADDR_WIDTH+1  active pixels per line; sampled on an accepted in_sof pixel.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  input accept; a transfer occurs when in_valid && in_ready.
- in_sof  in  1  first pixel of frame, qualified by in_valid.
- in_data  in  DATA_WIDTH  pixel.
- out_valid  out  1  tap column valid.
- out_ready  in  1  downstream accept.
- out_data  out  (NUM_LINES+1)*DATA_WIDTH  taps; slice 0 = current row, slice k = row minus k.
- out_col  out  ADDR_WIDTH  column index of the column.
- out_eol  out  1  column is the last of its line.
- out_rows_ok  out  1  all NUM_LINES previous rows hold current-frame data.

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, out_col=0, out_eol=0, out_rows_ok=0.
  - col=0, row_cnt=0, line_len=LINE_WIDTH.
  - in_ready=1 after reset (in_ready is combinational from pipeline state).
  - RAM contents are not cleared; stale data is masked by out_rows_ok.
- Pipeline enable: en = out_ready || !out_valid_final; in_ready = en.
  - All pipeline registers and RAM read clock-enables advance only when en=1, so a stall holds RAM output, as rd_clk_en does.
  - A bubble (en=1, in_valid=0) advances an invalid slot.
- Latency: an accepted pixel appears on out_* 1 cycle later (OUTPUT_REG=0) or 2 cycles later (OUTPUT_REG=1), measured in enabled cycles.
- Column counter:
  - Accepted in_sof forces this pixel to col=0 and row_cnt=0, and latches line_len = clamp(cfg_line_len, 4, LINE_WIDTH).
  - Otherwise col increments per accepted pixel; at col==line_len-1, out_eol=1, the next col is 0, and row_cnt increments, saturating at NUM_LINES.
  - in_sof mid-line aborts the line; no partial-line repair.
- Line memories: on accepting pixel at col c, every line RAM k reads address c.
  - Cycle t+1: the registered read of line k-1 (line 0 uses the registered in_data) is written to line k at the registered address c.
  - Net effect: each RAM shifts down one row per line time.
  - Because line_len>=4, a write and a read never target the same address in the same cycle; no bypass is needed.
- out_rows_ok = (row_cnt at acceptance >= NUM_LINES); it travels with the pixel through the pipeline.
- Stall at line wrap: the counter updates only on acceptance, so no skipped or duplicated columns.
- Reset mid-frame: the pipeline is flushed and the first pixel after reset is treated as col 0 of an unknown row (rows_ok=0) until in_sof.
- Widths: row_cnt is clog2(NUM_LINES+1) bits; no arithmetic on pixel data.

Decomposition:
- Package conv_buf_pkg:
  - localparams for default DATA_WIDTH / LINE_WIDTH / ADDR_WIDTH.
  - MIN_LINE_LEN=4.
  - A function for the tap slice index.
- Sub-module sdpram_core: single-clock simple dual-port RAM.
  - Ports: wr_en, wr_addr, wr_data, rd_addr, rd_clk_en, rd_data.
  - Read latency 1, optional output register, rd_clk_en gates the read register.
  - Instantiated NUM_LINES times by a generate loop.

Test Plan:
- Line fill: NUM_LINES=2, line_len=8, frame of 3 lines with pixel = row*16+col, out_ready=1.
  - Row 2, col 5 output: out_data = {0x05,0x15,0x25} (slice2..0), out_rows_ok=1.
  - out_rows_ok=0 for rows 0-1.
  - out_eol=1 at col 7.
- Backpressure: toggle out_ready 1-0-0-1 pseudo-randomly over a 16x4 frame.
  - Output sequence is identical to the no-stall reference model.
  - No pixel lost or duplicated.
  - in_ready=0 exactly when out_valid=1 and out_ready=0.
- Latency: OUTPUT_REG=0 vs 1, single pixel 0xA5 with in_sof.
  - out_valid rises 1 resp. 2 cycles after acceptance.
  - Slice 0 = 0xA5, out_col=0.
- Clamp and wrap: cfg_line_len=2 gives line_len 4 (eol every 4 pixels); cfg_line_len=600 gives 512.
  - Col 511 is followed by col 0 with row_cnt incremented.
- Mid-line sof: in_sof at col 3 of row 1.
  - Next output col=0, out_rows_ok=0.
  - The new line_len is taken from cfg_line_len at that pixel.
- Async reset: assert rst for 1 cycle mid-line between clock edges.
  - Outputs are 0 immediately, without waiting for a clock edge.
  - After release, in_ready=1 and rows_ok stays 0 until 2 full lines after the next in_sof.

Source files
------------

// File: rtl/conv_buf_pkg.sv
// Shared constants and helpers for the convolution line buffer.
package conv_buf_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_LINE_WIDTH = 512;
    localparam int DEFAULT_ADDR_WIDTH = 9;

    // Shortest line the buffer accepts; this keeps a line RAM write and the
    // next read on different addresses, so no bypass path is needed.
    localparam int MIN_LINE_LEN = 4;

    // Bit offset of tap slice 'tap' inside the packed tap column
    // (slice 0 = current row, slice k = k rows above).
    function automatic int tapLsb(input int tap, input int dataWidth);
        return tap * dataWidth;
    endfunction

endpackage

// File: rtl/sdpram_core.sv
// Single-clock simple dual-port RAM with a registered read port and an
// optional second output register. rd_clk_en freezes the read pipeline.
module sdpram_core #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 512,
    parameter int OUT_REG    = 0
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_clk_en,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdData_q;

    // Write port: contents are never cleared, consumers mask stale data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; holding rd_clk_en low keeps the last word visible.
    always_ff @(posedge clk) begin
        if (rd_clk_en) begin
            rdData_q <= mem[rd_addr];
        end
    end

    generate
        if (OUT_REG != 0) begin : g_outReg
            logic [DATA_WIDTH-1:0] outData_q;

            // Optional second read stage, gated by the same enable.
            always_ff @(posedge clk) begin
                if (rd_clk_en) begin
                    outData_q <= rdData_q;
                end
            end

            assign rd_data = outData_q;
        end else begin : g_noOutReg
            assign rd_data = rdData_q;
        end
    endgenerate

endmodule

// File: rtl/conv_line_buffer.sv
// Multi-line buffer for the Conv path: turns a raster pixel stream into
// vertical tap columns (current row plus NUM_LINES previous rows).
module conv_line_buffer
    import conv_buf_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LINE_WIDTH = DEFAULT_LINE_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int NUM_LINES  = 2,
    parameter int OUTPUT_REG = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [ADDR_WIDTH:0]                 cfg_line_len,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                in_sof,
    input  logic [DATA_WIDTH-1:0]               in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [(NUM_LINES+1)*DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0]               out_col,
    output logic                                out_eol,
    output logic                                out_rows_ok
);

    localparam int TAP_W = (NUM_LINES + 1) * DATA_WIDTH;
    localparam int ROW_W = $clog2(NUM_LINES + 1);
    localparam int LEN_W = ADDR_WIDTH + 1;
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(NUM_LINES);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LINE_LEN);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(LINE_WIDTH);

    logic                  en;
    logic                  accept;

    logic [ADDR_WIDTH-1:0] col_q, col_d;
    logic [ROW_W-1:0]      rowCnt_q, rowCnt_d;
    logic [LEN_W-1:0]      lineLen_q, lineLen_d;
    logic                  frameSeen_q, frameSeen_d;

    logic [ADDR_WIDTH-1:0] pixCol;
    logic [ROW_W-1:0]      pixRow;
    logic [LEN_W-1:0]      pixLen;
    logic                  pixFrame;
    logic                  pixEol;
    logic                  pixRowsOk;

    logic                  s1Valid_q;
    logic [DATA_WIDTH-1:0] s1Data_q;
    logic [ADDR_WIDTH-1:0] s1Col_q;
    logic                  s1Eol_q;
    logic                  s1RowsOk_q;
    logic [TAP_W-1:0]      s1Taps;
    logic                  ramWrEn;

    logic [DATA_WIDTH-1:0] lineRd [NUM_LINES];
    logic [DATA_WIDTH-1:0] lineWr [NUM_LINES];

    // The whole pipeline moves together; it only stalls when the final
    // stage holds a column the consumer has not taken.
    assign en       = out_ready || !out_valid;
    assign in_ready = en;
    assign accept   = in_valid && en;

    // Position of the pixel on the input (an sof restarts at col 0, row 0
    // with a freshly clamped line length) and the counter update on accept.
    always_comb begin
        pixCol   = col_q;
        pixRow   = rowCnt_q;
        pixLen   = lineLen_q;
        pixFrame = frameSeen_q;
        if (in_sof) begin
            pixCol   = '0;
            pixRow   = '0;
            pixFrame = 1'b1;
            if (cfg_line_len < LEN_MIN) begin
                pixLen = LEN_MIN;
            end else if (cfg_line_len > LEN_MAX) begin
                pixLen = LEN_MAX;
            end else begin
                pixLen = cfg_line_len;
            end
        end
        pixEol    = ({1'b0, pixCol} == (pixLen - LEN_W'(1)));
        pixRowsOk = pixFrame && (pixRow >= ROW_MAX);

        col_d       = col_q;
        rowCnt_d    = rowCnt_q;
        lineLen_d   = lineLen_q;
        frameSeen_d = frameSeen_q;
        if (accept) begin
            lineLen_d   = pixLen;
            frameSeen_d = pixFrame;
            if (pixEol) begin
                col_d    = '0;
                rowCnt_d = (pixRow < ROW_MAX) ? pixRow + ROW_W'(1) : pixRow;
            end else begin
                col_d    = pixCol + ADDR_WIDTH'(1);
                rowCnt_d = pixRow;
            end
        end
    end

    // Raster position state; after reset the stream is an unknown row until sof.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            rowCnt_q    <= '0;
            lineLen_q   <= LEN_MAX;
            frameSeen_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            rowCnt_q    <= rowCnt_d;
            lineLen_q   <= lineLen_d;
            frameSeen_q <= frameSeen_d;
        end
    end

    // First pipeline stage, aligned with the line RAM read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid_q  <= 1'b0;
            s1Data_q   <= '0;
            s1Col_q    <= '0;
            s1Eol_q    <= 1'b0;
            s1RowsOk_q <= 1'b0;
        end else if (en) begin
            s1Valid_q  <= accept;
            s1Data_q   <= in_data;
            s1Col_q    <= pixCol;
            s1Eol_q    <= pixEol;
            s1RowsOk_q <= pixRowsOk;
        end
    end

    // A column is pushed one row deeper exactly once, as it leaves stage 1.
    assign ramWrEn = s1Valid_q && en;

    assign s1Taps[tapLsb(0, DATA_WIDTH) +: DATA_WIDTH] = s1Data_q;

    generate
        for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
            if (k == 0) begin : g_head
                assign lineWr[k] = s1Data_q;
            end else begin : g_chain
                assign lineWr[k] = lineRd[k-1];
            end

            sdpram_core #(
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_WIDTH (ADDR_WIDTH),
                .DEPTH      (LINE_WIDTH),
                .OUT_REG    (0)
            ) u_lineRam (
                .clk       (clk),
                .wr_en     (ramWrEn),
                .wr_addr   (s1Col_q),
                .wr_data   (lineWr[k]),
                .rd_addr   (pixCol),
                .rd_clk_en (en),
                .rd_data   (lineRd[k])
            );

            assign s1Taps[tapLsb(k + 1, DATA_WIDTH) +: DATA_WIDTH] = lineRd[k];
        end

        if (OUTPUT_REG != 0) begin : g_outReg
            logic             s2Valid_q;
            logic [TAP_W-1:0] s2Data_q;
            logic [ADDR_WIDTH-1:0] s2Col_q;
            logic             s2Eol_q;
            logic             s2RowsOk_q;

            // Extra output stage for timing; invalid slots carry zero data.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2Valid_q  <= 1'b0;
                    s2Data_q   <= '0;
                    s2Col_q    <= '0;
                    s2Eol_q    <= 1'b0;
                    s2RowsOk_q <= 1'b0;
                end else if (en) begin
                    s2Valid_q  <= s1Valid_q;
                    s2Data_q   <= s1Valid_q ? s1Taps : '0;
                    s2Col_q    <= s1Col_q;
                    s2Eol_q    <= s1Eol_q;
                    s2RowsOk_q <= s1RowsOk_q;
                end
            end

            assign out_valid   = s2Valid_q;
            assign out_data    = s2Data_q;
            assign out_col     = s2Col_q;
            assign out_eol     = s2Eol_q;
            assign out_rows_ok = s2RowsOk_q;
        end else begin : g_noOutReg
            assign out_valid   = s1Valid_q;
            assign out_data    = s1Valid_q ? s1Taps : '0;
            assign out_col     = s1Col_q;
            assign out_eol     = s1Eol_q;
            assign out_rows_ok = s1RowsOk_q;
        end
    endgenerate

endmodule

// File: tb/tb_conv_line_buffer.sv
// Scoreboard bench for conv_line_buffer: dut0 without and dut1 with the
// output register, both against a frame-image reference model.
module tb_conv_line_buffer;

    localparam int NL = 2;
    localparam int DW = 8;
    localparam int AW = 9;
    localparam int TW = (NL + 1) * DW;

    typedef struct {
        logic [TW-1:0] data;
        logic [AW-1:0] col;
        logic          eol;
        logic          rowsOk;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          inValid   [2];
    logic          inReady   [2];
    logic          inSof     [2];
    logic [DW-1:0] inData    [2];
    logic [AW:0]   cfgLen    [2];
    logic          outValid  [2];
    logic          outReady  [2];
    logic [TW-1:0] outData   [2];
    logic [AW-1:0] outCol    [2];
    logic          outEol    [2];
    logic          outRowsOk [2];
    bit            bpEnable  [2];
    bit            accepted  [2];

    int vectors     = 0;
    int miscompares = 0;

    exp_t expQ0[$];
    exp_t expQ1[$];

    // Reference model: position in the frame and every pixel seen, by (row, col).
    int mCol   [2];
    int mRow   [2];
    int mLen   [2];
    bit mFrame [2];
    int img    [int];

    always #5 clk = ~clk;

    conv_line_buffer #(
        .DATA_WIDTH (DW), .LINE_WIDTH (512), .ADDR_WIDTH (AW),
        .NUM_LINES (NL), .OUTPUT_REG (0)
    ) uA (
        .clk (clk), .rst (rst), .cfg_line_len (cfgLen[0]),
        .in_valid (inValid[0]), .in_ready (inReady[0]), .in_sof (inSof[0]),
        .in_data (inData[0]), .out_valid (outValid[0]), .out_ready (outReady[0]),
        .out_data (outData[0]), .out_col (outCol[0]), .out_eol (outEol[0]),
        .out_rows_ok (outRowsOk[0])
    );

    conv_line_buffer #(
        .DATA_WIDTH (DW), .LINE_WIDTH (512), .ADDR_WIDTH (AW),
        .NUM_LINES (NL), .OUTPUT_REG (1)
    ) uB (
        .clk (clk), .rst (rst), .cfg_line_len (cfgLen[1]),
        .in_valid (inValid[1]), .in_ready (inReady[1]), .in_sof (inSof[1]),
        .in_data (inData[1]), .out_valid (outValid[1]), .out_ready (outReady[1]),
        .out_data (outData[1]), .out_col (outCol[1]), .out_eol (outEol[1]),
        .out_rows_ok (outRowsOk[1])
    );

    function automatic int pixKey(input int d, input int row, input int col);
        return d * (1 << 24) + row * 1024 + col;
    endfunction

    // Expected column for an accepted pixel, derived from the frame image.
    task automatic modelAccept(input int d);
        exp_t e;
        int   len;
        if (inSof[d]) begin
            len       = int'(cfgLen[d]);
            mCol[d]   = 0;
            mRow[d]   = 0;
            mFrame[d] = 1'b1;
            mLen[d]   = (len < 4) ? 4 : ((len > 512) ? 512 : len);
        end
        e.col    = AW'(mCol[d]);
        e.eol    = (mCol[d] == mLen[d] - 1);
        e.rowsOk = mFrame[d] && (mRow[d] >= NL);
        e.data   = '0;
        e.data[DW-1:0] = inData[d];
        img[pixKey(d, mRow[d], mCol[d])] = int'(inData[d]);
        if (e.rowsOk) begin
            for (int k = 1; k <= NL; k++) begin
                e.data[k*DW +: DW] = DW'(img[pixKey(d, mRow[d] - k, mCol[d])]);
            end
        end
        if (e.eol) begin
            mCol[d] = 0;
            mRow[d] = mRow[d] + 1;
        end else begin
            mCol[d] = mCol[d] + 1;
        end
        if (d == 0) expQ0.push_back(e);
        else        expQ1.push_back(e);
    endtask

    // Stimulus side of the scoreboard: a handshake seen here completes on
    // the next rising edge. Reset flushes the model and pending columns.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                accepted[d] = 1'b0;
                mCol[d]     = 0;
                mRow[d]     = 0;
                mLen[d]     = 512;
                mFrame[d]   = 1'b0;
            end else begin
                accepted[d] = inValid[d] && inReady[d];
                if (accepted[d]) modelAccept(d);
            end
        end
        if (rst) begin
            expQ0.delete();
            expQ1.delete();
        end
    end

    task automatic checkOutput(input int d);
        exp_t          e;
        bit            have;
        logic [TW-1:0] mask;
        vectors++;
        if (inReady[d] !== !(outValid[d] && !outReady[d])) begin
            miscompares++;
            $display("[TB] FAIL handshake dut%0d: in_ready=%b out_valid=%b out_ready=%b, required in_ready=%b",
                     d, inReady[d], outValid[d], outReady[d], !(outValid[d] && !outReady[d]));
        end
        if (outValid[d] && outReady[d]) begin
            vectors++;
            have = (d == 0) ? (expQ0.size() > 0) : (expQ1.size() > 0);
            if (!have) begin
                miscompares++;
                $display("[TB] FAIL unexpected column dut%0d: got col=%0d data=%h, required none",
                         d, outCol[d], outData[d]);
            end else begin
                if (d == 0) e = expQ0.pop_front();
                else        e = expQ1.pop_front();
                mask = e.rowsOk ? {TW{1'b1}} : {{(TW-DW){1'b0}}, {DW{1'b1}}};
                if (((outData[d] & mask) !== e.data) || (outCol[d] !== e.col) ||
                    (outEol[d] !== e.eol) || (outRowsOk[d] !== e.rowsOk)) begin
                    miscompares++;
                    $display("[TB] FAIL column dut%0d: got data=%h col=%0d eol=%b rows_ok=%b, required data=%h col=%0d eol=%b rows_ok=%b (mask %h)",
                             d, outData[d] & mask, outCol[d], outEol[d], outRowsOk[d],
                             e.data, e.col, e.eol, e.rowsOk, mask);
                end
            end
        end
    endtask

    // Output side of the scoreboard, independent of the stimulus.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput(0);
            checkOutput(1);
        end
    end

    // Downstream ready: always on, or a random stall pattern when enabled.
    always begin
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            outReady[d] = bpEnable[d] ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Presents one pixel (called at posedge+1) and returns at posedge+1 of
    // the edge that accepted it.
    task automatic applyStimulus(input int d, input logic [DW-1:0] data,
                                 input logic sof, input int cfg);
        int waitCnt;
        inValid[d] = 1'b1;
        inSof[d]   = sof;
        inData[d]  = data;
        cfgLen[d]  = (AW+1)'(cfg);
        waitCnt    = 0;
        do begin
            @(posedge clk);
            waitCnt++;
        end while (!accepted[d] && waitCnt < 100);
        #1;
        inValid[d] = 1'b0;
        inSof[d]   = 1'b0;
        if (!accepted[d]) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept timeout dut%0d: got in_ready stuck low, required accept within 100 cycles", d);
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendFrame(input int d, input int cfg, input int rows, input int cols,
                             input bit randData, input int gapMax);
        logic [DW-1:0] px;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                px = randData ? DW'($urandom) : DW'(r * 16 + c);
                applyStimulus(d, px, (r == 0 && c == 0), cfg);
                idle($urandom_range(0, gapMax));
            end
        end
    endtask

    task automatic measureLatency(input int d, input int required);
        int lat;
        applyStimulus(d, 8'hA5, 1'b1, 8);
        lat = 1;
        while (!outValid[d] && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("latency dut%0d", d), 32'(lat), 32'(required));
        idle(3);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            inValid[d]  = 1'b0;
            inSof[d]    = 1'b0;
            inData[d]   = '0;
            cfgLen[d]   = '0;
            bpEnable[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid dut0", 32'(outValid[0]), 0);
        check("reset out_data dut0", 32'(outData[0]), 0);
        check("reset out_col dut0", 32'(outCol[0]), 0);
        check("reset out_eol dut0", 32'(outEol[0]), 0);
        check("reset out_rows_ok dut0", 32'(outRowsOk[0]), 0);
        check("reset in_ready dut0", 32'(inReady[0]), 1);
        check("reset out_valid dut1", 32'(outValid[1]), 0);
        check("reset out_data dut1", 32'(outData[1]), 0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] latency");
        measureLatency(0, 1);
        measureLatency(1, 2);

        $display("[TB] line fill 3x8, pixel = row*16+col");
        sendFrame(0, 8, 3, 8, 1'b0, 0);

        $display("[TB] backpressure 16x4");
        bpEnable[0] = 1'b1;
        sendFrame(0, 16, 4, 16, 1'b1, 1);
        bpEnable[1] = 1'b1;
        sendFrame(1, 10, 4, 10, 1'b1, 1);
        bpEnable[1] = 1'b0;

        $display("[TB] clamp low and high");
        bpEnable[0] = 1'b0;
        sendFrame(0, 2, 3, 4, 1'b1, 0);
        sendFrame(0, 600, 3, 512, 1'b1, 0);

        $display("[TB] sof in mid-line");
        sendFrame(0, 8, 1, 8, 1'b1, 0);
        for (int c = 0; c < 3; c++) applyStimulus(0, DW'($urandom), 1'b0, 8);
        sendFrame(0, 6, 3, 6, 1'b1, 0);

        $display("[TB] random frames");
        bpEnable[0] = 1'b1;
        for (int f = 0; f < 3; f++) begin
            int len;
            len = $urandom_range(4, 12);
            sendFrame(0, len, $urandom_range(3, 4), len, 1'b1, 2);
        end

        $display("[TB] async reset mid-line");
        bpEnable[0] = 1'b0;
        idle(4);
        for (int c = 0; c < 12; c++) applyStimulus(0, DW'($urandom), (c == 0), 8);
        #2 rst = 1'b1;
        #1;
        check("async reset out_valid", 32'(outValid[0]), 0);
        check("async reset out_data", 32'(outData[0]), 0);
        check("async reset out_col", 32'(outCol[0]), 0);
        check("async reset out_rows_ok", 32'(outRowsOk[0]), 0);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("post reset in_ready", 32'(inReady[0]), 1);
        @(posedge clk);
        #1;
        for (int c = 0; c < 5; c++) applyStimulus(0, DW'($urandom), 1'b0, 8);
        bpEnable[0] = 1'b1;
        sendFrame(0, 8, 3, 8, 1'b1, 1);

        bpEnable[0] = 1'b0;
        idle(10);
        check("drain dut0", 32'(expQ0.size()), 0);
        check("drain dut1", 32'(expQ1.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
